// File: rtl/ac_pkg.sv
// ac_pkg
// Shared constants for the AV1 arithmetic-encoder pipeline stages.
// Holds the encoder count reset value, the default signed count width,
// the pre-carry word size and the renormalisation offsets used by
// stage 3.
package ac_pkg;

    // Default signed width of the encoder cnt register.
    localparam int CNT_WIDTH         = 6;

    // cnt value after reset.
    localparam int CNT_RESET         = -9;

    // Significant bits in a pre-carry word; bit 8 carries into the previous byte.
    localparam int PRECARRY_BITS     = 9;

    // Renormalisation offsets: c = cnt + 16, step 8 per word, cnt = c + d - 24.
    localparam int RENORM_C_OFFSET   = 16;
    localparam int RENORM_STEP       = 8;
    localparam int RENORM_CNT_OFFSET = 24;

endpackage

// File: rtl/leading_zero.sv
// leading_zero
// Combinational leading-zero counter.
// Ports:
//   value  in   WIDTH            word to inspect
//   count  out  $clog2(WIDTH)+1  number of zeros above the highest set bit
//                                (WIDTH when value is zero)
module leading_zero #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         value,
    output logic [$clog2(WIDTH):0]   count
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Scan from LSB upwards so the highest set bit makes the last assignment.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/stage_3_renorm_buffered_precarry_fifo.sv
// precarry_fifo
// Two-write / one-read FIFO holding pre-carry words.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   push_first    write data_first at the write pointer
//   push_second   write data_second one slot after data_first (only with push_first)
//   data_first    first (older) word of this cycle
//   data_second   second word of this cycle
//   out_ready     consumer takes the head this cycle
//   out_valid     head is valid
//   out_data      registered head word, held when the FIFO is empty
//   occupancy     number of stored words
// The producer guarantees no overflow by looking at occupancy.
module precarry_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_first,
    input  logic                      push_second,
    input  logic [WIDTH-1:0]          data_first,
    input  logic [WIDTH-1:0]          data_second,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    count;
    logic [WIDTH-1:0] head_q;

    logic             pop;
    logic [OW-1:0]    num_push;
    logic [OW-1:0]    remaining;
    logic [PW-1:0]    next_rd;

    assign pop       = (count != '0) && out_ready;
    assign num_push  = OW'(push_first) + OW'(push_second);
    assign remaining = count - OW'(pop);
    assign next_rd   = rd_ptr + PW'(pop);

    always_ff @(posedge clk) begin
        if (push_first) begin
            mem[wr_ptr] <= data_first;
        end
        if (push_second) begin
            mem[wr_ptr + PW'(1)] <= data_second;
        end
    end

    // The head is registered. If older words survive the pop, the next head
    // comes from memory; if not, a word pushed this cycle bypasses straight
    // into the head. With nothing left, the last head value is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(num_push);
            rd_ptr <= next_rd;
            count  <= remaining + num_push;
            if (remaining != '0) begin
                head_q <= mem[next_rd];
            end else if (push_first) begin
                head_q <= data_first;
            end
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = head_q;
    assign occupancy = count;

endmodule

// File: rtl/stage_3_renorm_buffered.sv
// stage_3_renorm_buffered
// Renormalisation stage of the AV1 arithmetic encoder. Owns low/cnt,
// normalises each range by its leading-zero count and emits 0..2 pre-carry
// words per symbol into a buffered output (od_ec_encode semantics).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/ready    symbol handshake; ready needs two free buffer entries
//   in_range          un-normalised range from stage 2
//   in_low_add        value added to low before renormalisation
//   out_valid/ready   pre-carry word handshake
//   out_data          pre-carry word (9 significant bits, zero-extended)
//   out_range         normalised range fed back to stage 1
//   out_range_valid   one-cycle pulse when out_range updates
//   state_low         current low
//   state_cnt         current cnt (signed)
//   err               sticky, set when a zero range is accepted
module stage_3_renorm_buffered #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 32,
    parameter int CNT_WIDTH   = ac_pkg::CNT_WIDTH,
    parameter int OUT_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RANGE_WIDTH-1:0] in_range,
    input  logic [LOW_WIDTH-1:0]   in_low_add,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [RANGE_WIDTH-1:0] out_range,
    output logic                   out_range_valid,
    output logic [LOW_WIDTH-1:0]   state_low,
    output logic [CNT_WIDTH-1:0]   state_cnt,
    output logic                   err
);

    import ac_pkg::*;

    localparam int LZ_W  = $clog2(RANGE_WIDTH) + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] READY_MAX = OCC_W'(FIFO_DEPTH - 2);

    logic [LOW_WIDTH-1:0]          low_q;
    logic signed [CNT_WIDTH-1:0]   cnt_q;
    logic [RANGE_WIDTH-1:0]        out_range_q;
    logic                          out_range_valid_q;
    logic                          err_q;

    logic [LZ_W-1:0]               lz;
    logic [OCC_W-1:0]              occupancy;
    logic                          accept;
    logic                          range_zero;
    logic                          do_update;

    logic                          emit_first;
    logic                          emit_second;
    logic [OUT_WIDTH-1:0]          word_first;
    logic [OUT_WIDTH-1:0]          word_second;
    logic [OUT_WIDTH-1:0]          word_tail;
    logic [LOW_WIDTH-1:0]          l_work;
    logic [LOW_WIDTH-1:0]          low_next;
    logic [CNT_WIDTH-1:0]          cnt_next;
    logic [RANGE_WIDTH-1:0]        range_next;
    int                            d_i;
    int                            cnt_i;
    int                            s_i;
    int                            c_i;

    leading_zero #(
        .WIDTH (RANGE_WIDTH)
    ) u_leading_zero (
        .value (in_range),
        .count (lz)
    );

    // Readiness uses registered occupancy only, so a pop this cycle does not help.
    assign in_ready   = (occupancy <= READY_MAX);
    assign accept     = in_valid && in_ready;
    assign range_zero = (in_range == '0);
    assign do_update  = accept && !range_zero;

    // Single-cycle renormalisation. c counts the bit position of the next
    // word boundary in low; each emitted word takes the bits above c and
    // clears them. When two words come out, the high one is emitted first.
    always_comb begin
        l_work      = low_q + in_low_add;
        d_i         = int'(lz);
        cnt_i       = int'(cnt_q);
        s_i         = cnt_i + d_i;
        c_i         = cnt_i + RENORM_C_OFFSET;
        emit_first  = 1'b0;
        emit_second = 1'b0;
        word_first  = '0;
        word_second = '0;
        word_tail   = '0;
        cnt_next    = CNT_WIDTH'(s_i);
        if (s_i >= 0) begin
            emit_first = 1'b1;
            if (s_i >= RENORM_STEP) begin
                emit_second = 1'b1;
                word_first  = OUT_WIDTH'(l_work >> c_i);
                l_work      = l_work & ~({LOW_WIDTH{1'b1}} << c_i);
                c_i         = c_i - RENORM_STEP;
            end
            word_tail = OUT_WIDTH'(l_work >> c_i);
            l_work    = l_work & ~({LOW_WIDTH{1'b1}} << c_i);
            if (emit_second) begin
                word_second = word_tail;
            end else begin
                word_first = word_tail;
            end
            cnt_next = CNT_WIDTH'(c_i + d_i - RENORM_CNT_OFFSET);
        end
        low_next   = l_work << d_i;
        range_next = in_range << d_i;
    end

    // Encoder state; a zero range only raises err and leaves everything else alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_q             <= '0;
            cnt_q             <= CNT_WIDTH'(CNT_RESET);
            out_range_q       <= '0;
            out_range_valid_q <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            out_range_valid_q <= do_update;
            if (do_update) begin
                low_q       <= low_next;
                cnt_q       <= cnt_next;
                out_range_q <= range_next;
            end
            if (accept && range_zero) begin
                err_q <= 1'b1;
            end
        end
    end

    precarry_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_precarry_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_first  (do_update && emit_first),
        .push_second (do_update && emit_second),
        .data_first  (word_first),
        .data_second (word_second),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .occupancy   (occupancy)
    );

    assign out_range       = out_range_q;
    assign out_range_valid = out_range_valid_q;
    assign state_low       = low_q;
    assign state_cnt       = cnt_q;
    assign err             = err_q;

endmodule

// File: tb/tb_stage_3_renorm_buffered.sv
// tb_stage_3_renorm_buffered
// Directed bench for stage_3_renorm_buffered with hand-computed expectations.
// Scenarios run in order and chain encoder state from one to the next.
module tb_stage_3_renorm_buffered;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_range;
    logic [31:0] in_low_add;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_range;
    logic        out_range_valid;
    logic [31:0] state_low;
    logic [5:0]  state_cnt;
    logic        err;

    int checks;
    int passes;

    stage_3_renorm_buffered #(
        .RANGE_WIDTH (16),
        .LOW_WIDTH   (32),
        .CNT_WIDTH   (6),
        .OUT_WIDTH   (16),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_range        (in_range),
        .in_low_add      (in_low_add),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_range       (out_range),
        .out_range_valid (out_range_valid),
        .state_low       (state_low),
        .state_cnt       (state_cnt),
        .err             (err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one symbol for exactly one edge.
    task automatic send(input logic [15:0] rng, input logic [31:0] add);
        in_valid   = 1'b1;
        in_range   = rng;
        in_low_add = add;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (state_cnt !== 6'h37) $display("[TB] FAIL reset_cnt got %h want 37", state_cnt); else passes++;
        checks++; if (state_low !== 32'h0) $display("[TB] FAIL reset_low got %h want 0", state_low); else passes++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0) $display("[TB] FAIL reset_out_data got %h want 0", out_data); else passes++;
        checks++; if (out_range !== 16'h0) $display("[TB] FAIL reset_out_range got %h want 0", out_range); else passes++;
        checks++; if (out_range_valid !== 1'b0) $display("[TB] FAIL reset_range_valid got %b want 0", out_range_valid); else passes++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", err); else passes++;
    endtask

    // d = 0, s = -9: no word, low just accumulates.
    task automatic test_no_emit();
        send(16'h8000, 32'h1234);
        checks++; if (state_low !== 32'h1234) $display("[TB] FAIL noemit_low got %h want 1234", state_low); else passes++;
        checks++; if (state_cnt !== 6'h37) $display("[TB] FAIL noemit_cnt got %h want 37", state_cnt); else passes++;
        checks++; if (out_range !== 16'h8000) $display("[TB] FAIL noemit_range got %h want 8000", out_range); else passes++;
        checks++; if (out_range_valid !== 1'b1) $display("[TB] FAIL noemit_range_valid got %b want 1", out_range_valid); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL noemit_out_valid got %b want 0", out_valid); else passes++;
        step();
        checks++; if (out_range_valid !== 1'b0) $display("[TB] FAIL noemit_pulse_end got %b want 0", out_range_valid); else passes++;
    endtask

    // From reset: d = 15, s = 6, one word 0x180 >> 7 = 3.
    task automatic test_single_emit();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b0;
        send(16'h0001, 32'h0000_0180);
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL single_valid got %b want 1", out_valid); else passes++;
        checks++; if (out_data !== 16'h0003) $display("[TB] FAIL single_data got %h want 0003", out_data); else passes++;
        checks++; if (state_cnt !== 6'h3E) $display("[TB] FAIL single_cnt got %h want 3e", state_cnt); else passes++;
        checks++; if (state_low !== 32'h0) $display("[TB] FAIL single_low got %h want 0", state_low); else passes++;
        checks++; if (out_range !== 16'h8000) $display("[TB] FAIL single_range got %h want 8000", out_range); else passes++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL single_pop_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0003) $display("[TB] FAIL single_empty_hold got %h want 0003", out_data); else passes++;
    endtask

    // cnt = -2, d = 15, s = 13: words 0x101 then 0x001.
    task automatic test_double_emit();
        send(16'h0001, 32'h0040_4040);
        checks++; if (out_data !== 16'h0101) $display("[TB] FAIL double_first got %h want 0101", out_data); else passes++;
        checks++; if (state_cnt !== 6'h3D) $display("[TB] FAIL double_cnt got %h want 3d", state_cnt); else passes++;
        checks++; if (state_low !== 32'h0) $display("[TB] FAIL double_low got %h want 0", state_low); else passes++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL double_in_ready got %b want 1", in_ready); else passes++;
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 16'h0001) $display("[TB] FAIL double_second got %h want 0001", out_data); else passes++;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL double_second_valid got %b want 1", out_valid); else passes++;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL double_drained got %b want 0", out_valid); else passes++;
    endtask

    // Fill the buffer with two double-emitting symbols, then drain it.
    // A: cnt -3, c 13 -> 0x0AB, 0x055.  B: cnt -4, c 12 -> 0x1C3, 0x00F.
    task automatic test_back_to_back();
        logic [15:0] exp_data  [4];
        logic        exp_ready [4];
        logic        exp_valid [4];
        exp_data  = '{16'h0055, 16'h01C3, 16'h000F, 16'h000F};
        exp_ready = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_valid = '{1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b0;
        send(16'h0001, 32'h0015_6AA0);
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_half got %b want 1", in_ready); else passes++;
        checks++; if (state_cnt !== 6'h3C) $display("[TB] FAIL b2b_cnt_a got %h want 3c", state_cnt); else passes++;
        send(16'h0001, 32'h001C_30F0);
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL b2b_ready_full got %b want 0", in_ready); else passes++;
        checks++; if (state_cnt !== 6'h3B) $display("[TB] FAIL b2b_cnt_b got %h want 3b", state_cnt); else passes++;
        checks++; if (out_data !== 16'h00AB) $display("[TB] FAIL b2b_head got %h want 00ab", out_data); else passes++;
        send(16'h8000, 32'h0000_0010);
        checks++; if (state_low !== 32'h0) $display("[TB] FAIL b2b_reject_low got %h want 0", state_low); else passes++;
        checks++; if (out_range_valid !== 1'b0) $display("[TB] FAIL b2b_reject_pulse got %b want 0", out_range_valid); else passes++;
        checks++; if (out_data !== 16'h00AB) $display("[TB] FAIL b2b_head_stable got %h want 00ab", out_data); else passes++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_data !== exp_data[i]) $display("[TB] FAIL b2b_drain_data[%0d] got %h want %h", i, out_data, exp_data[i]); else passes++;
            checks++; if (in_ready !== exp_ready[i]) $display("[TB] FAIL b2b_drain_ready[%0d] got %b want %b", i, in_ready, exp_ready[i]); else passes++;
            checks++; if (out_valid !== exp_valid[i]) $display("[TB] FAIL b2b_drain_valid[%0d] got %b want %b", i, out_valid, exp_valid[i]); else passes++;
        end
        out_ready = 1'b0;
    endtask

    // Zero range raises err and changes nothing else; err then stays set.
    task automatic test_zero_range();
        send(16'h0000, 32'h0000_1234);
        checks++; if (err !== 1'b1) $display("[TB] FAIL zero_err got %b want 1", err); else passes++;
        checks++; if (state_low !== 32'h0) $display("[TB] FAIL zero_low got %h want 0", state_low); else passes++;
        checks++; if (state_cnt !== 6'h3B) $display("[TB] FAIL zero_cnt got %h want 3b", state_cnt); else passes++;
        checks++; if (out_range !== 16'h8000) $display("[TB] FAIL zero_range got %h want 8000", out_range); else passes++;
        checks++; if (out_range_valid !== 1'b0) $display("[TB] FAIL zero_pulse got %b want 0", out_range_valid); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL zero_out_valid got %b want 0", out_valid); else passes++;
        send(16'h4000, 32'h0000_0005);
        checks++; if (err !== 1'b1) $display("[TB] FAIL zero_sticky got %b want 1", err); else passes++;
        checks++; if (state_low !== 32'h0000_000A) $display("[TB] FAIL zero_next_low got %h want a", state_low); else passes++;
        checks++; if (state_cnt !== 6'h3C) $display("[TB] FAIL zero_next_cnt got %h want 3c", state_cnt); else passes++;
    endtask

    // cnt -4, low 0xA, add 0x101010: L = 0x10101A -> 0x101, 0x001; then reset.
    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(16'h0001, 32'h0010_1010);
        checks++; if (out_data !== 16'h0101) $display("[TB] FAIL mid_head got %h want 0101", out_data); else passes++;
        checks++; if (state_low !== 32'h0005_0000) $display("[TB] FAIL mid_low got %h want 50000", state_low); else passes++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0) $display("[TB] FAIL mid_reset_data got %h want 0", out_data); else passes++;
        checks++; if (state_cnt !== 6'h37) $display("[TB] FAIL mid_reset_cnt got %h want 37", state_cnt); else passes++;
        checks++; if (state_low !== 32'h0) $display("[TB] FAIL mid_reset_low got %h want 0", state_low); else passes++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL mid_reset_err got %b want 0", err); else passes++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_reset_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_range !== 16'h0) $display("[TB] FAIL mid_reset_range got %h want 0", out_range); else passes++;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_range   = '0;
        in_low_add = '0;
        out_ready  = 1'b0;
        test_reset();
        test_no_emit();
        test_single_emit();
        test_double_emit();
        test_back_to_back();
        test_zero_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stage_3_renorm_buffered.md
# stage_3_renorm_buffered

Sequential, parametrised renormalisation stage for the AV1 arithmetic-encoder pipeline. It owns the encoder `low` and `cnt` state, and it normalises each incoming range with a leading-zero count. It emits 0, 1 or 2 pre-carry words per symbol into an internal output buffer, using libaom `od_ec_encode` renormalisation semantics. Valid/ready handshakes on both sides let downstream carry-resolution and byte-packing logic apply backpressure.

## Interface
Parameters:
- `RANGE_WIDTH`, 16: range width.
- `LOW_WIDTH`, 32: internal `low` register width. Must be ≥ `RANGE_WIDTH`+15.
- `CNT_WIDTH`, 6: signed width of `cnt`.
- `OUT_WIDTH`, 16: pre-carry word width. Values are at most 9 significant bits, zero-extended.
- `FIFO_DEPTH`, 4: output buffer entries. Must be ≥ 2 and a power of two.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  symbol presented.
- `in_ready`  out  1  block can accept a symbol.
- `in_range`  in  `RANGE_WIDTH`  un-normalised new range from stage 2.
- `in_low_add`  in  `LOW_WIDTH`  value added to `low` before renormalisation.
- `out_valid`  out  1  buffer head valid.
- `out_ready`  in  1  consumer takes head.
- `out_data`  out  `OUT_WIDTH`  pre-carry word.
- `out_range`  out  `RANGE_WIDTH`  normalised range, fed back to stage 1.
- `out_range_valid`  out  1  one-cycle pulse; `out_range` updated.
- `state_low`  out  `LOW_WIDTH`  current `low`, exported for the flush/done logic.
- `state_cnt`  out  `CNT_WIDTH`  current `cnt`, signed.
- `err`  out  1  sticky; set when a zero range is accepted.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready` = (free entries ≥ 2), computed from the registered occupancy only. A pop in the same cycle does not raise it.
- On accept, compute in a single cycle:
  - L = `low` + `in_low_add`, modulo 2^`LOW_WIDTH`.
  - d = leading zeros of `in_range`, in the range 0..15.
  - s = `cnt` + d, signed.
- If s < 0: no word is emitted; `cnt` ← s.
- If s ≥ 0:
  - c = `cnt` + 16.
  - If s ≥ 8: push L>>c; L &= 2^c−1; c −= 8.
  - Then push L>>c; L &= 2^c−1.
  - `cnt` ← c + d − 24.
- In all cases: `low` ← L<<d; `out_range` ← `in_range`<<d; pulse `out_range_valid`.
- Two words are pushed in the same cycle, in order: the high word is written to the lower buffer index and reaches the head first.
- Invariants: `cnt` stays in [−9, 6]; each pre-carry word is < 2^9, with bit 8 being the carry.
- `in_range` = 0: `err` ← 1. `low`, `cnt`, `out_range` and the buffer are left unchanged, and `out_range_valid` is not pulsed.
- Buffer pop: `out_valid && out_ready`. A push and a pop in the same cycle are both honoured; occupancy changes by pushes − pop. Read and write pointers wrap modulo `FIFO_DEPTH`.
- `out_data` is driven from the registered head. It holds stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `cnt` = −9, `low` = 0, occupancy = 0.
  - `out_valid` = 0, `out_data` = 0, `in_ready` = 1.
  - `out_range` = 0, `out_range_valid` = 0, `err` = 0.
- Reset mid-operation discards all buffered words and all state in the same edge.
- Latency: a word pushed at edge N is visible on `out_valid`/`out_data` after edge N. `out_range`, `state_low` and `state_cnt` also update at edge N.
- Throughput: 1 symbol/cycle while the consumer drains at ≥ the emission rate.
- Full condition: occupancy > `FIFO_DEPTH`−2 ⇒ `in_ready` = 0.
- Empty condition: `out_valid` = 0 and `out_data` is held.

## Structure
- Shared package `ac_pkg`: `CNT_RESET` (−9), `CNT_WIDTH`, `PRECARRY_BITS` (9), renorm offsets 16/8/24.
- Leading-zero count: reuse the existing `leading_zero` module.
- Sub-module `precarry_fifo`: a 2-write/1-read FIFO with occupancy output. The renorm datapath and state registers stay in the top module.

## Test plan
- Reset, then idle → `cnt` = −9, `low` = 0, `in_ready` = 1, `out_valid` = 0.
- `in_range` = 0x8000, add 0x1234 → d = 0, no word; `low` = 0x1234, `cnt` = −9, `out_range` = 0x8000.
- From reset: `in_range` = 0x0001, add 0x180 → one word 0x0003; `cnt` = −2, `low` = 0, `out_range` = 0x8000.
- Continue from the previous case: `in_range` = 0x0001, add 0x00404040 → words 0x0101 then 0x0001; `cnt` = −3, `low` = 0.
- With `out_ready` = 0 and `FIFO_DEPTH` = 4, send two double-emitting symbols → occupancy 4, `in_ready` = 0. Release `out_ready` → the 4 words drain in order and `in_ready` rises when occupancy ≤ 2.
- `in_range` = 0 → `err` = 1 and sticky, state unchanged. Assert `reset` with a non-empty buffer → empty and reset values on the next cycle.
